// File: rtl/imem_pkg.sv
// Shared types and helpers for the boot-loaded instruction memory.
// Holds the sequencer state encoding, the latency ceiling and a clog2 helper.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_START,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN
  } imem_state_e;

  localparam int BOOT_LAT_MAX = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/boot_loaded_imem_file_if.sv
// Boot-ROM fetch, CPU write port and CPU read port of the instruction memory.
// Optional LOCK/LOCKED pair exists only when IMEM_WRITE_LOCK_EN is defined.
interface boot_loaded_imem_file_if
  import imem_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = clog2(DEPTH);

  logic             REBOOT;
  logic             BOOT_RD;
  logic [AW-1:0]    BOOT_ADDR;
  logic [WIDTH-1:0] BOOT_DATA;
  logic             WRITE_ENABLE;
  logic [AW-1:0]    WRITE_SELECT;
  logic [WIDTH-1:0] IMEM_INPUT;
  logic [AW-1:0]    READ_SELECT;
  logic [WIDTH-1:0] IMEM_OUTPUT;
  logic             BOOT_BUSY;
  logic             BOOT_DONE;
  logic             WRITE_ERR;
`ifdef IMEM_WRITE_LOCK_EN
  logic             LOCK;
  logic             LOCKED;
`endif

  modport master (
`ifdef IMEM_WRITE_LOCK_EN
    output LOCK,
    input  LOCKED,
`endif
    output REBOOT, BOOT_DATA, WRITE_ENABLE, WRITE_SELECT, IMEM_INPUT, READ_SELECT,
    input  BOOT_RD, BOOT_ADDR, IMEM_OUTPUT, BOOT_BUSY, BOOT_DONE, WRITE_ERR
  );

  modport slave (
`ifdef IMEM_WRITE_LOCK_EN
    input  LOCK,
    output LOCKED,
`endif
    input  REBOOT, BOOT_DATA, WRITE_ENABLE, WRITE_SELECT, IMEM_INPUT, READ_SELECT,
    output BOOT_RD, BOOT_ADDR, IMEM_OUTPUT, BOOT_BUSY, BOOT_DONE, WRITE_ERR
  );

endinterface

// File: rtl/imem_boot_sequencer.sv
// Boot fill sequencer and write-port arbiter (optional IMEM_WRITE_LOCK_EN lock).
// One ROM word per clock, BOOT_LAT-edge capture delay; no backpressure, CPU writes outside RUN are rejected.
module imem_boot_sequencer
  import imem_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int BOOT_LAT = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reboot,
`ifdef IMEM_WRITE_LOCK_EN
  input  logic             lock,
  output logic             locked,
`endif
  input  logic [WIDTH-1:0] boot_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_sel,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             boot_rd,
  output logic [AW-1:0]    boot_addr,
  output logic             boot_busy,
  output logic             boot_done,
  output logic             write_err,
  output logic             mem_we,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH-1:0] mem_wdat
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  imem_state_e   state_q, state_d;
  logic          boot_rd_d;
  logic [AW-1:0] boot_addr_d;

  logic          sr_vld_q  [BOOT_LAT_MAX-1];
  logic [AW-1:0] sr_addr_q [BOOT_LAT_MAX-1];
  logic          tap_vld   [BOOT_LAT_MAX];
  logic [AW-1:0] tap_addr  [BOOT_LAT_MAX];

  logic          fill_we;
  logic [AW-1:0] fill_addr;
  logic          in_range;
  logic          cpu_ok;

  // Tap 0 is the address on the ROM bus right now; tap k is that address k edges ago.
  always_comb begin
    tap_vld[0]  = boot_rd;
    tap_addr[0] = boot_addr;
    for (int i = 1; i < BOOT_LAT_MAX; i++) begin
      tap_vld[i]  = sr_vld_q[i-1];
      tap_addr[i] = sr_addr_q[i-1];
    end
  end

  assign fill_we   = tap_vld[BOOT_LAT-1];
  assign fill_addr = tap_addr[BOOT_LAT-1];
  assign in_range  = ({1'b0, wr_sel} < DEPTH_W);

`ifdef IMEM_WRITE_LOCK_EN
  assign cpu_ok = wr_en && (state_q == ST_RUN) && in_range && !locked;
`else
  assign cpu_ok = wr_en && (state_q == ST_RUN) && in_range;
`endif

  // Fill and CPU writes never coincide: fills only land in LOAD/DRAIN.
  assign mem_we    = fill_we || cpu_ok;
  assign mem_waddr = fill_we ? fill_addr : wr_sel;
  assign mem_wdat  = fill_we ? boot_data : wr_dat;

  always_comb begin
    state_d     = state_q;
    boot_rd_d   = boot_rd;
    boot_addr_d = boot_addr;
    unique case (state_q)
      ST_START: begin
        state_d     = ST_LOAD;
        boot_rd_d   = 1'b1;
        boot_addr_d = '0;
      end
      ST_LOAD: begin
        boot_addr_d = boot_addr + 1'b1;
        if (boot_addr_d == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        boot_rd_d = 1'b0;
        if (fill_we && (fill_addr == LAST_ADDR)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (reboot) begin
          state_d     = ST_LOAD;
          boot_rd_d   = 1'b1;
          boot_addr_d = '0;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_START;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_rd   <= 1'b0;
      boot_addr <= '0;
      boot_busy <= 1'b1;
      boot_done <= 1'b0;
      write_err <= 1'b0;
      for (int i = 0; i < BOOT_LAT_MAX-1; i++) begin
        sr_vld_q[i]  <= 1'b0;
        sr_addr_q[i] <= '0;
      end
    end else begin
      boot_rd      <= boot_rd_d;
      boot_addr    <= boot_addr_d;
      boot_busy    <= (state_d != ST_RUN);
      boot_done    <= (state_d == ST_RUN);
      write_err    <= wr_en && !cpu_ok;
      sr_vld_q[0]  <= boot_rd;
      sr_addr_q[0] <= boot_addr;
      for (int i = 1; i < BOOT_LAT_MAX-1; i++) begin
        sr_vld_q[i]  <= sr_vld_q[i-1];
        sr_addr_q[i] <= sr_addr_q[i-1];
      end
    end
  end

`ifdef IMEM_WRITE_LOCK_EN
  // Sticky until reset; a reboot fill still runs while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked <= 1'b0;
    else        locked <= locked || (lock && (state_q == ST_RUN));
  end
`endif

endmodule

// File: rtl/boot_loaded_imem_file.sv
// Instruction memory that self-fills from a boot ROM, then serves CPU write/read (IMEM_WRITE_LOCK_EN adds write lock).
// Boot takes DEPTH+BOOT_LAT edges; reads are combinational; rejected writes report on WRITE_ERR, no stalls.
module boot_loaded_imem_file
  import imem_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int BOOT_LAT = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input logic                   CLOCK,
  input logic                   RESET_N,
  boot_loaded_imem_file_if.slave bus
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdat;

  imem_boot_sequencer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .BOOT_LAT (BOOT_LAT)
  ) u_seq (
    .clk       (CLOCK),
    .rst_n     (RESET_N),
    .reboot    (bus.REBOOT),
`ifdef IMEM_WRITE_LOCK_EN
    .lock      (bus.LOCK),
    .locked    (bus.LOCKED),
`endif
    .boot_data (bus.BOOT_DATA),
    .wr_en     (bus.WRITE_ENABLE),
    .wr_sel    (bus.WRITE_SELECT),
    .wr_dat    (bus.IMEM_INPUT),
    .boot_rd   (bus.BOOT_RD),
    .boot_addr (bus.BOOT_ADDR),
    .boot_busy (bus.BOOT_BUSY),
    .boot_done (bus.BOOT_DONE),
    .write_err (bus.WRITE_ERR),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdat  (mem_wdat)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  // Out-of-range selects only exist when DEPTH is not a power of two.
  always_comb begin
    bus.IMEM_OUTPUT = '0;
    if ({1'b0, bus.READ_SELECT} < DEPTH_W) bus.IMEM_OUTPUT = mem[bus.READ_SELECT];
  end

endmodule

// File: tb/tb_boot_loaded_imem_file.sv
// Bench for boot_loaded_imem_file: a default instance (comb ROM) and a DEPTH 12 / BOOT_LAT 2 instance (sync ROM).
module tb_boot_loaded_imem_file;
  import imem_pkg::*;

  localparam int DA  = 16;
  localparam int LA  = 1;
  localparam int DB  = 12;
  localparam int LB  = 2;
  localparam int T_A = DA + LA;
  localparam int T_B = DB + LB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mdl_a [DA];
  logic [15:0] mdl_b [DB];
  logic [15:0] rom_b;

  boot_loaded_imem_file_if #(.WIDTH(16), .DEPTH(DA)) ifa ();
  boot_loaded_imem_file_if #(.WIDTH(16), .DEPTH(DB)) ifb ();

  boot_loaded_imem_file #(.WIDTH(16), .DEPTH(DA), .BOOT_LAT(LA)) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .bus(ifa.slave));
  boot_loaded_imem_file #(.WIDTH(16), .DEPTH(DB), .BOOT_LAT(LB)) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .bus(ifb.slave));

  assign ifa.BOOT_DATA = 16'hA000 + 16'(ifa.BOOT_ADDR);
  always @(posedge clk) rom_b <= 16'hA000 + 16'(ifb.BOOT_ADDR);
  assign ifb.BOOT_DATA = rom_b;

`ifdef IMEM_WRITE_LOCK_EN
  initial begin
    ifa.LOCK = 1'b0;
    ifb.LOCK = 1'b0;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_b(input int a);
    return (a < DB) ? mdl_b[a] : 16'h0000;
  endfunction

  task automatic load_rom_model();
    for (int i = 0; i < DA; i++) mdl_a[i] = 16'hA000 + 16'(i);
    for (int i = 0; i < DB; i++) mdl_b[i] = 16'hA000 + 16'(i);
  endtask

  task automatic check_reads(input string tag);
    for (int i = 0; i < 16; i++) begin
      ifa.READ_SELECT = 4'(i);
      ifb.READ_SELECT = 4'(i);
      #1;
      chk({tag, "_rd_a"}, ifa.IMEM_OUTPUT, mdl_a[i]);
      chk({tag, "_rd_b"}, ifb.IMEM_OUTPUT, ref_b(i));
    end
  endtask

  // Runs from just after reset release until both instances should be done.
  task automatic run_boot(input bit poke);
    int nxt_a, nxt_b;
    nxt_a = 0;
    nxt_b = 0;
    for (int e = 1; e <= T_A; e++) begin
      if (poke && e == 5) begin
        ifa.WRITE_ENABLE = 1'b1;
        ifa.WRITE_SELECT = 4'd3;
        ifa.IMEM_INPUT   = 16'h1234;
      end
      tick();
      ifa.WRITE_ENABLE = 1'b0;
      if (poke && e == 5) chk("boot_wr_err_pulse", ifa.WRITE_ERR, 1);
      if (poke && e == 6) chk("boot_wr_err_clear", ifa.WRITE_ERR, 0);
      if (ifa.BOOT_RD) begin
        chk("boot_addr_a", ifa.BOOT_ADDR, nxt_a);
        nxt_a++;
      end
      if (ifb.BOOT_RD) begin
        chk("boot_addr_b", ifb.BOOT_ADDR, nxt_b);
        nxt_b++;
      end
      chk("done_a", ifa.BOOT_DONE, e >= T_A);
      chk("busy_a", ifa.BOOT_BUSY, e < T_A);
      chk("done_b", ifb.BOOT_DONE, e >= T_B);
    end
    chk("issued_a", nxt_a, DA);
    chk("issued_b", nxt_b, DB);
  endtask

  initial begin
    int n;
    logic [15:0] d_a, d_b;
    int wa, wb;
    bit we_a, we_b;

    rst_n = 1'b0;
    ifa.REBOOT = 0; ifa.WRITE_ENABLE = 0; ifa.WRITE_SELECT = '0; ifa.IMEM_INPUT = '0; ifa.READ_SELECT = '0;
    ifb.REBOOT = 0; ifb.WRITE_ENABLE = 0; ifb.WRITE_SELECT = '0; ifb.IMEM_INPUT = '0; ifb.READ_SELECT = '0;
    repeat (2) tick();

    chk("rst_boot_rd", ifa.BOOT_RD, 0);
    chk("rst_boot_addr", ifa.BOOT_ADDR, 0);
    chk("rst_busy", ifa.BOOT_BUSY, 1);
    chk("rst_done", ifa.BOOT_DONE, 0);
    chk("rst_werr", ifa.WRITE_ERR, 0);
    chk("rst_read", ifa.IMEM_OUTPUT, 0);
    chk("rst_busy_b", ifb.BOOT_BUSY, 1);

    // Initial boot with a rejected write attempted on boot edge 5.
    rst_n = 1'b1;
    run_boot(1'b1);
    load_rom_model();
    check_reads("boot");

    // Same-cycle read/write of one address: old value first, new after the edge.
    ifa.READ_SELECT  = 4'd7;
    ifa.WRITE_ENABLE = 1'b1;
    ifa.WRITE_SELECT = 4'd7;
    ifa.IMEM_INPUT   = 16'hBEEF;
    #1;
    chk("rw_same_old", ifa.IMEM_OUTPUT, 16'hA007);
    tick();
    ifa.WRITE_ENABLE = 1'b0;
    mdl_a[7] = 16'hBEEF;
    chk("rw_same_new", ifa.IMEM_OUTPUT, 16'hBEEF);
    chk("rw_no_err", ifa.WRITE_ERR, 0);

    // Random write/read traffic on both instances.
    for (int k = 0; k < 40; k++) begin
      we_a = 1'($urandom_range(0, 1));
      we_b = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, DA - 1);
      wb = $urandom_range(0, 15);
      d_a = 16'($urandom);
      d_b = 16'($urandom);
      ifa.WRITE_ENABLE = we_a; ifa.WRITE_SELECT = 4'(wa); ifa.IMEM_INPUT = d_a;
      ifb.WRITE_ENABLE = we_b; ifb.WRITE_SELECT = 4'(wb); ifb.IMEM_INPUT = d_b;
      ifa.READ_SELECT = 4'($urandom_range(0, 15));
      ifb.READ_SELECT = 4'($urandom_range(0, 15));
      #1;
      chk("rnd_rd_a", ifa.IMEM_OUTPUT, mdl_a[int'(ifa.READ_SELECT)]);
      chk("rnd_rd_b", ifb.IMEM_OUTPUT, ref_b(int'(ifb.READ_SELECT)));
      tick();
      if (we_a) mdl_a[wa] = d_a;
      if (we_b && wb < DB) mdl_b[wb] = d_b;
      chk("rnd_err_a", ifa.WRITE_ERR, 0);
      chk("rnd_err_b", ifb.WRITE_ERR, we_b && (wb >= DB));
    end
    ifa.WRITE_ENABLE = 0;
    ifb.WRITE_ENABLE = 0;
    check_reads("rnd");

    // Reboot with a simultaneous write; a second REBOOT mid-fill must be ignored.
    ifa.REBOOT = 1'b1;
    ifa.WRITE_ENABLE = 1'b1;
    ifa.WRITE_SELECT = 4'd2;
    ifa.IMEM_INPUT = 16'h5555;
    ifa.READ_SELECT = 4'd2;
    tick();
    ifa.REBOOT = 1'b0;
    ifa.WRITE_ENABLE = 1'b0;
    chk("reboot_busy", ifa.BOOT_BUSY, 1);
    chk("reboot_done", ifa.BOOT_DONE, 0);
    chk("reboot_wr_ok", ifa.WRITE_ERR, 0);
    chk("reboot_wr_data", ifa.IMEM_OUTPUT, 16'h5555);
    n = 1;
    while (!ifa.BOOT_DONE && n < 40) begin
      if (n == 5) ifa.REBOOT = 1'b1;
      tick();
      ifa.REBOOT = 1'b0;
      n++;
    end
    chk("reboot_len", n, T_A);
    for (int i = 0; i < DA; i++) mdl_a[i] = 16'hA000 + 16'(i);
    check_reads("reboot");

    // Reset asserted on the 8th edge of a reboot fill.
    ifa.REBOOT = 1'b1;
    tick();
    ifa.REBOOT = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < DA; i++) mdl_a[i] = '0;
    for (int i = 0; i < DB; i++) mdl_b[i] = '0;
    ifa.READ_SELECT = 4'd7;
    ifb.READ_SELECT = 4'd3;
    #1;
    chk("midrst_boot_rd", ifa.BOOT_RD, 0);
    chk("midrst_boot_addr", ifa.BOOT_ADDR, 0);
    chk("midrst_busy", ifa.BOOT_BUSY, 1);
    chk("midrst_done", ifa.BOOT_DONE, 0);
    chk("midrst_rd_a", ifa.IMEM_OUTPUT, mdl_a[7]);
    chk("midrst_rd_b", ifb.IMEM_OUTPUT, mdl_b[3]);
    tick();
    rst_n = 1'b1;
    run_boot(1'b0);
    load_rom_model();
    check_reads("reboot_rst");

    // Out-of-range write on the DEPTH 12 instance.
    ifb.WRITE_ENABLE = 1'b1;
    ifb.WRITE_SELECT = 4'd13;
    ifb.IMEM_INPUT = 16'hFFFF;
    tick();
    ifb.WRITE_ENABLE = 1'b0;
    chk("oor_err_pulse", ifb.WRITE_ERR, 1);
    tick();
    chk("oor_err_clear", ifb.WRITE_ERR, 0);
    ifb.READ_SELECT = 4'd13;
    #1;
    chk("oor_read", ifb.IMEM_OUTPUT, ref_b(13));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
